// File: rtl/dir_ctrl.sv
// Direction controller: synchronizes and debounces a pushbutton, toggles dir on
// each debounced press, and optionally auto-reverses dir every SWEEP_CYCLES clocks.
module dir_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SWEEP_CYCLES    = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic mode,
    output logic dir,
    output logic btn_db,
    output logic press
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(SWEEP_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] SW_LAST = SW'(SWEEP_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO,
        WAIT_HI,
        STABLE_HI,
        WAIT_LO
    } db_state_t;

    db_state_t     state;
    logic          s1;
    logic          s2;
    logic [DW-1:0] db_cnt;
    logic [SW-1:0] sw_cnt;
    logic          rise;
    logic          sweep_tc;

    // Events decided this edge; both feed the dir toggle so a coincident press
    // and sweep terminal count collapse into a single toggle.
    // NOTE: combinational blocks assign every output unconditionally so no latch is inferred.
    always_comb begin
        rise     = (state == WAIT_HI) && s2 && (db_cnt == DB_LAST);
        sweep_tc = mode && (sw_cnt == SW_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            state  <= STABLE_LO;
            db_cnt <= '0;
            btn_db <= 1'b0;
            press  <= 1'b0;
            sw_cnt <= '0;
            dir    <= 1'b0;
        end else begin
            s1    <= btn_raw;
            s2    <= s1;
            press <= rise;

            case (state)
                STABLE_LO: begin
                    if (s2) begin
                        state  <= WAIT_HI;
                        db_cnt <= DW'(1);
                    end else begin
                        db_cnt <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!s2) begin
                        state  <= STABLE_LO;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state  <= STABLE_HI;
                        btn_db <= 1'b1;
                        db_cnt <= '0;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end
                STABLE_HI: begin
                    if (!s2) begin
                        state  <= WAIT_LO;
                        db_cnt <= DW'(1);
                    end else begin
                        db_cnt <= '0;
                    end
                end
                WAIT_LO: begin
                    if (s2) begin
                        state  <= STABLE_HI;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state  <= STABLE_LO;
                        btn_db <= 1'b0;
                        db_cnt <= '0;
                    end else begin
                        db_cnt <= db_cnt + DW'(1);
                    end
                end
                default: begin
                    state  <= STABLE_LO;
                    db_cnt <= '0;
                end
            endcase

            // A press restarts the sweep period; leaving sweep mode parks the counter at 0.
            if (!mode || rise || sweep_tc) begin
                sw_cnt <= '0;
            end else begin
                sw_cnt <= sw_cnt + SW'(1);
            end

            if (rise || sweep_tc) begin
                dir <= ~dir;
            end
        end
    end

endmodule

// File: tb/tb_dir_ctrl.sv
// Self-checking bench for dir_ctrl: directed vector table, hand-written corner
// sequences, and a randomized run against a run-length/phase reference model.
module tb_dir_ctrl;

    localparam int DB = 4;
    localparam int SW = 8;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic btn_raw = 1'b0;
    logic mode    = 1'b0;
    logic dir;
    logic btn_db;
    logic press;

    int n_checks = 0;
    int n_fail   = 0;

    dir_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .SWEEP_CYCLES   (SW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_raw),
        .mode   (mode),
        .dir    (dir),
        .btn_db (btn_db),
        .press  (press)
    );

    always #5 clk = ~clk;

    // Reference model: two-sample delay line, length of the current run of
    // samples disagreeing with the debounced level, and clocks into the sweep period.
    bit sync_q[$];
    int run;
    int phase;
    bit m_db;
    bit m_press;
    bit m_dir;

    typedef struct {
        string    name;
        bit       r;
        bit       b;
        bit       m;
        int       n;
        bit [2:0] exp;   // {dir, btn_db, press}
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit b, input bit m);
        bit used;
        bit rose;
        if (r) begin
            sync_q  = '{1'b0, 1'b0};
            run     = 0;
            phase   = 0;
            m_db    = 1'b0;
            m_press = 1'b0;
            m_dir   = 1'b0;
            return;
        end
        used = sync_q[$];
        sync_q.pop_back();
        sync_q.push_front(b);

        rose = 1'b0;
        if (used != m_db) begin
            run++;
            if (run == DB) begin
                m_db = !m_db;
                run  = 0;
                rose = m_db;
            end
        end else begin
            run = 0;
        end
        m_press = rose;

        if (!m || rose) begin
            phase = 0;
        end else begin
            phase++;
            if (phase == SW) begin
                phase = 0;
                m_dir = !m_dir;
            end
        end
        if (rose) m_dir = !m_dir;
    endtask

    task automatic cycle(input bit r, input bit b, input bit m);
        rst     = r;
        btn_raw = b;
        mode    = m;
        @(posedge clk);
        model_edge(r, b, m);
        #1;
        check("model", {dir, btn_db, press}, {m_dir, m_db, m_press});
    endtask

    task automatic add_vec(input string name, input bit r, input bit b, input bit m,
                           input int n, input bit [2:0] exp);
        vec_t v;
        v.name = name;
        v.r    = r;
        v.b    = b;
        v.m    = m;
        v.n    = n;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    initial begin
        bit rb;
        bit rm;
        bit rr;
        int hold;

        sync_q = '{1'b0, 1'b0};

        add_vec("reset",      1, 0, 0, 3, 3'b000);
        add_vec("rise_e5",    0, 1, 0, 5, 3'b000);
        add_vec("rise_e6",    0, 1, 0, 1, 3'b111);
        add_vec("rise_e7",    0, 1, 0, 1, 3'b110);
        add_vec("hold_hi",    0, 1, 0, 5, 3'b110);
        add_vec("fall_e5",    0, 0, 0, 5, 3'b110);
        add_vec("fall_e6",    0, 0, 0, 1, 3'b100);
        add_vec("hold_lo",    0, 0, 0, 6, 3'b100);
        add_vec("bounce_hi3", 0, 1, 0, 3, 3'b100);
        add_vec("bounce_lo1", 0, 0, 0, 1, 3'b100);
        add_vec("bounce_e5",  0, 1, 0, 5, 3'b100);
        add_vec("bounce_e6",  0, 1, 0, 1, 3'b011);
        add_vec("bounce_e7",  0, 1, 0, 4, 3'b010);
        add_vec("release",    0, 0, 0, 8, 3'b000);

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) cycle(vecs[i].r, vecs[i].b, vecs[i].m);
            check(vecs[i].name, {dir, btn_db, press}, vecs[i].exp);
        end

        // Sweep: toggles at edges 8, 16, 24; mode drops at edge 26 and dir freezes.
        for (int e = 1; e <= 45; e++) begin
            cycle(0, 0, (e <= 25));
            if (e == 7)  check("sweep_e7",  {2'b00, dir}, 3'b000);
            if (e == 8)  check("sweep_e8",  {2'b00, dir}, 3'b001);
            if (e == 16) check("sweep_e16", {2'b00, dir}, 3'b000);
            if (e == 24) check("sweep_e24", {2'b00, dir}, 3'b001);
            if (e == 45) check("sweep_frozen", {2'b00, dir}, 3'b001);
        end

        // Press lands on the sweep terminal count: one toggle, next sweep 8 edges on.
        for (int e = 1; e <= 16; e++) begin
            cycle(0, (e >= 3), 1);
            if (e == 7)  check("coinc_e7",  {dir, btn_db, press}, 3'b100);
            if (e == 8)  check("coinc_e8",  {dir, btn_db, press}, 3'b011);
            if (e == 15) check("coinc_e15", {dir, btn_db, press}, 3'b010);
            if (e == 16) check("coinc_e16", {dir, btn_db, press}, 3'b110);
        end
        for (int e = 1; e <= 10; e++) cycle(0, 0, 0);
        check("coinc_release", {dir, btn_db, press}, 3'b100);

        // Reset mid-debounce with the button held: press 6 edges after reset drops.
        for (int e = 1; e <= 11; e++) begin
            cycle((e == 4), 1, 0);
            if (e == 4)  check("rst_mid",  {dir, btn_db, press}, 3'b000);
            if (e == 9)  check("rst_e9",   {dir, btn_db, press}, 3'b000);
            if (e == 10) check("rst_e10",  {dir, btn_db, press}, 3'b111);
            if (e == 11) check("rst_e11",  {dir, btn_db, press}, 3'b110);
        end

        // Randomized run: button held for short random spans, occasional mode flips and resets.
        rb   = 1'b0;
        rm   = 1'b0;
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                rb   = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 7);
            end
            hold--;
            if ($urandom_range(0, 59) == 0) rm = !rm;
            rr = ($urandom_range(0, 199) == 0);
            cycle(rr, rb, rm);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
